// File: rtl/br_param.sv
// br_param: parameterised 2R1W register bank with a self-clearing start-up FSM.
// Define BR_BYPASS_EN to forward same-cycle writes to the read ports.
module br_param #(
   parameter  int XLEN     = 32,
   parameter  int NREG     = 32,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   a1,
   input  logic [AW-1:0]   a2,
   input  logic [AW-1:0]   a3,
   input  logic [XLEN-1:0] wd3,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            ready
);

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t          state;
   logic [AW-1:0]   clr_cnt;
   logic            ready_q;
   logic [XLEN-1:0] regs [NREG];

   logic            a1_ok;
   logic            a2_ok;
   logic            a3_ok;
   logic            wr_ok;

   // address qualification: out-of-range and hardwired-zero slots are dead
   always_comb begin
      a1_ok = (int'(a1) < NREG);
      a2_ok = (int'(a2) < NREG);
      a3_ok = (int'(a3) < NREG);
      if (ZERO_REG != 0) begin
         if (a1 == '0) a1_ok = 1'b0;
         if (a2 == '0) a2_ok = 1'b0;
         if (a3 == '0) a3_ok = 1'b0;
      end
      wr_ok = (state == RUN) && !rst && we && a3_ok;
   end

   // read ports: zero while clearing or for dead addresses, optional bypass
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (state == RUN) begin
         if (a1_ok) rd1 = regs[a1];
         if (a2_ok) rd2 = regs[a2];
`ifdef BR_BYPASS_EN
         if (wr_ok && (a1 == a3)) rd1 = wd3;
         if (wr_ok && (a2 == a3)) rd2 = wd3;
`else
`endif
      end
   end

   // clear sequencer and write port
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         ready_q <= 1'b0;
      end else begin
         unique case (state)
            CLEAR: begin
               regs[clr_cnt] <= '0;
               if (clr_cnt == AW'(NREG - 1)) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            RUN: begin
               if (wr_ok) regs[a3] <= wd3;
            end
         endcase
      end
   end

   assign ready = ready_q;

endmodule

// File: tb/tb_br_param.sv
// tb_br_param: directed checks of br_param in three builds
// (default, ZERO_REG=0, NREG=24) sharing one stimulus bus.
module tb_br_param;

`ifdef BR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [4:0]  a3;
   logic [31:0] wd3;

   logic [31:0] rd1_a, rd2_a, rd1_z, rd2_z, rd1_n, rd2_n;
   logic        rdy_a, rdy_z, rdy_n;

   int errors;
   int checks;

   br_param dut (
      .clk(clk), .rst(rst), .we(we), .a1(a1), .a2(a2), .a3(a3),
      .wd3(wd3), .rd1(rd1_a), .rd2(rd2_a), .ready(rdy_a)
   );

   br_param #(.ZERO_REG(0)) dut_z (
      .clk(clk), .rst(rst), .we(we), .a1(a1), .a2(a2), .a3(a3),
      .wd3(wd3), .rd1(rd1_z), .rd2(rd2_z), .ready(rdy_z)
   );

   br_param #(.NREG(24)) dut_n (
      .clk(clk), .rst(rst), .we(we), .a1(a1), .a2(a2), .a3(a3),
      .wd3(wd3), .rd1(rd1_n), .rd2(rd2_n), .ready(rdy_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int n_a, n_z, n_n, bad;
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({rdy_a, rdy_z, rdy_n} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready got %b want 000", {rdy_a, rdy_z, rdy_n});
      end
      rst = 1'b0;
      a1  = 5'd1;
      n_a = 0; n_z = 0; n_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!rdy_a) n_a++;
         if (!rdy_z) n_z++;
         if (!rdy_n) n_n++;
         if (i == 5) begin
            checks++;
            if (rd1_a !== 32'h0) begin
               errors++;
               $display("FAIL clear_read got %h want 0", rd1_a);
            end
         end
         tick();
      end
      checks++;
      if (n_a !== 32) begin
         errors++;
         $display("FAIL clear_len32 got %0d want 32", n_a);
      end
      checks++;
      if (n_z !== 32) begin
         errors++;
         $display("FAIL clear_len32z got %0d want 32", n_z);
      end
      checks++;
      if (n_n !== 24) begin
         errors++;
         $display("FAIL clear_len24 got %0d want 24", n_n);
      end
      bad = 0;
      for (int a = 0; a < 32; a++) begin
         a1 = 5'(a);
         a2 = 5'(31 - a);
         #1;
         if (rd1_a !== 32'h0 || rd2_a !== 32'h0) bad++;
         if (rd1_z !== 32'h0 || rd1_n !== 32'h0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL post_clear_zero got %0d nonzero want 0", bad);
      end
   endtask

   task automatic test_write_read();
      we = 1'b1; a3 = 5'd3; wd3 = 32'h0123_3333;
      tick();
      we = 1'b0; a1 = 5'd3; a2 = 5'd2;
      #1;
      checks++;
      if (rd1_a !== 32'h0123_3333) begin
         errors++;
         $display("FAIL wr_rd1 got %h want 01233333", rd1_a);
      end
      checks++;
      if (rd2_a !== 32'h0) begin
         errors++;
         $display("FAIL wr_rd2 got %h want 0", rd2_a);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp;
      exp = BYP ? 32'h1234_5678 : 32'h0;
      we = 1'b1; a3 = 5'd5; wd3 = 32'h1234_5678; a1 = 5'd5; a2 = 5'd5;
      #1;
      checks++;
      if (rd1_a !== exp) begin
         errors++;
         $display("FAIL bypass_rd1 got %h want %h", rd1_a, exp);
      end
      checks++;
      if (rd2_a !== exp) begin
         errors++;
         $display("FAIL bypass_rd2 got %h want %h", rd2_a, exp);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (rd1_a !== 32'h1234_5678 || rd2_a !== 32'h1234_5678) begin
         errors++;
         $display("FAIL after_write got %h/%h want 12345678", rd1_a, rd2_a);
      end
   endtask

   task automatic test_zero_reg();
      we = 1'b1; a3 = 5'd0; wd3 = 32'hDEAD_BEEF; a1 = 5'd0; a2 = 5'd0;
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (rd1_a !== 32'h0) begin
         errors++;
         $display("FAIL zero_reg got %h want 0", rd1_a);
      end
      checks++;
      if (rd1_z !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL no_zero_reg got %h want deadbeef", rd1_z);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] exp;
      we = 1'b1; a3 = 5'd30; wd3 = 32'hAAAA_5555; a1 = 5'd30;
      #1;
      checks++;
      if (rd1_n !== 32'h0) begin
         errors++;
         $display("FAIL oob_fwd got %h want 0", rd1_n);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (rd1_n !== 32'h0) begin
         errors++;
         $display("FAIL oob_read got %h want 0", rd1_n);
      end
      checks++;
      if (rd1_a !== 32'hAAAA_5555) begin
         errors++;
         $display("FAIL r30_n32 got %h want aaaa5555", rd1_a);
      end
      for (int a = 0; a < 24; a++) begin
         a1 = 5'(a);
         #1;
         exp = (a == 3) ? 32'h0123_3333 :
               (a == 5) ? 32'h1234_5678 : 32'h0;
         checks++;
         if (rd1_n !== exp) begin
            errors++;
            $display("FAIL n24_reg%0d got %h want %h", a, rd1_n, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      we = 1'b1;
      a3 = 5'd7; wd3 = 32'h70; tick();
      a3 = 5'd8; wd3 = 32'h80; tick();
      a3 = 5'd9; wd3 = 32'h90; tick();
      a3 = 5'd7; wd3 = 32'h77; tick();
      we = 1'b0;
      a1 = 5'd7; a2 = 5'd8;
      #1;
      checks++;
      if (rd1_a !== 32'h77 || rd2_a !== 32'h80) begin
         errors++;
         $display("FAIL b2b_7_8 got %h/%h want 77/80", rd1_a, rd2_a);
      end
      a1 = 5'd9; a2 = 5'd9;
      #1;
      checks++;
      if (rd1_a !== 32'h90 || rd2_a !== 32'h90) begin
         errors++;
         $display("FAIL b2b_9 got %h/%h want 90/90", rd1_a, rd2_a);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      rst = 1'b1; we = 1'b1; a3 = 5'd6; wd3 = 32'h66; a1 = 5'd6;
      #1;
      checks++;
      if (rd1_a !== 32'h0) begin
         errors++;
         $display("FAIL rst_fwd got %h want 0", rd1_a);
      end
      tick();
      rst = 1'b0; a3 = 5'd4; wd3 = 32'hFFFF_FFFF; a1 = 5'd30;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!rdy_a) n++;
         if (i == 0) begin
            checks++;
            if (rd1_a !== 32'h0) begin
               errors++;
               $display("FAIL midclr_read got %h want 0", rd1_a);
            end
         end
         if (i == 20) we = 1'b0;
         tick();
      end
      checks++;
      if (n !== 32) begin
         errors++;
         $display("FAIL midclr_len got %0d want 32", n);
      end
      a1 = 5'd4; a2 = 5'd30;
      #1;
      checks++;
      if (rd1_a !== 32'h0 || rd2_a !== 32'h0) begin
         errors++;
         $display("FAIL midclr_regs got %h/%h want 0/0", rd1_a, rd2_a);
      end
      checks++;
      if (rd1_z !== 32'h0) begin
         errors++;
         $display("FAIL midclr_z4 got %h want 0", rd1_z);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1; we = 1'b0;
      a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/br_param.md
BR_PARAM -- requirements
Module: br_param

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning number of registers (2..256).
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 SHALL have derived localparam AW = clog2(NREG), meaning address width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 we  input  1  write enable for port 3.
REQ-008 a1  input  AW  read address, port 1.
REQ-009 a2  input  AW  read address, port 2.
REQ-010 a3  input  AW  write address, port 3.
REQ-011 wd3  input  XLEN  write data, port 3.
REQ-012 rd1  output  XLEN  read data, port 1, combinational from a1.
REQ-013 rd2  output  XLEN  read data, port 2, combinational from a2.
REQ-014 ready  output  1  high when the bank is in RUN and accepts writes.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-016 In CLEAR, each cycle SHALL write zero to register[clr_cnt] and increment clr_cnt by 1.
REQ-017 When clr_cnt == NREG-1 in CLEAR, the FSM SHALL move to RUN on that edge; the clear therefore takes exactly NREG cycles.
REQ-018 ready SHALL be 0 in CLEAR and 1 in RUN; it SHALL rise on the edge after the last register is cleared.
REQ-019 In CLEAR, we SHALL be ignored, and rd1 and rd2 SHALL read 0.
REQ-020 In RUN, when we=1, register[a3] SHALL take wd3 on the rising edge.
REQ-021 In RUN, rd1 = register[a1] and rd2 = register[a2], with no clock latency.
REQ-022 If ZERO_REG=1, a write to address 0 SHALL be discarded, and reads of address 0 SHALL return 0.
REQ-023 An address >= NREG (NREG not a power of 2) SHALL read 0, and writes to it SHALL be discarded.
REQ-024 If a1 == a2, both ports SHALL return identical data.
REQ-025 The FSM SHALL stay in RUN until rst; there is no other transition out of RUN.

Reset
REQ-026 When rst=1 at a rising edge, the FSM SHALL enter CLEAR, clr_cnt SHALL be 0, and ready SHALL be 0 on the next cycle.
REQ-027 rst asserted in CLEAR SHALL restart the clear from register 0.
REQ-028 rst asserted in RUN SHALL discard any simultaneous write.
REQ-029 While rst is held high, the FSM SHALL remain in CLEAR with clr_cnt at 0; the clear sequence SHALL start on the first edge with rst=0.

Configuration
REQ-030 The macro BR_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 When BR_BYPASS_EN is defined, ready=1, we=1, and a1==a3 (or a2==a3), the matching rd port SHALL return wd3 in the same cycle; writes that are discarded are never forwarded.
REQ-032 When BR_BYPASS_EN is not defined, the rd ports SHALL show the old register value until the edge after the write.

Verification
REQ-033 Reset with NREG=32: assert rst for 1 cycle -> ready=0 for exactly 32 cycles, then ready=1, and every address reads 0x00000000.
REQ-034 Write/read: in RUN, we=1, a3=3, wd3=0x01233333; next cycle a1=3, a2=2 -> rd1=0x01233333, rd2=0x00000000.
REQ-035 Zero register: we=1, a3=0, wd3=0xDEADBEEF; then a1=0 -> rd1=0; with ZERO_REG=0 -> rd1=0xDEADBEEF.
REQ-036 Bypass: we=1, a3=a1=5, wd3=0x12345678, old value 0 -> same-cycle rd1=0x12345678 with BR_BYPASS_EN defined, rd1=0 without it.
REQ-037 Reset mid-clear: assert rst at clear cycle 10 -> ready stays 0 for 32 further cycles; a write attempted during CLEAR (a3=4, wd3=0xFFFFFFFF) -> register 4 reads 0 after ready=1.
REQ-038 NREG=24 build: a3=30, we=1, wd3=0xAAAA5555 -> a1=30 reads 0, and registers 0..23 are unchanged.
